// File: rtl/bus85_mem_if.sv
// Core-side and memory/IO-side signal bundle for the bus85_mem adapter.
// The multiplexed AD bus stays a plain inout on the adapter.
interface bus85_mem_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16
);
  logic [ADDRSIZE-DATASIZE-1:0] addr;
  logic                         ale;
  logic                         iom_;
  logic                         rd_;
  logic                         wr_;
  logic                         ready;
  logic [ADDRSIZE-1:0]          mem_addr;
  logic [DATASIZE-1:0]          mem_wdata;
  logic                         mem_re;
  logic                         mem_we;
  logic [DATASIZE-1:0]          mem_rdata;
  logic                         io_rd;
  logic                         io_wr;
  logic [DATASIZE-1:0]          io_rdata;
  logic                         bus_err;

  modport slave (
    input  addr, ale, iom_, rd_, wr_, mem_rdata, io_rdata,
    output ready, mem_addr, mem_wdata, mem_re, mem_we, io_rd, io_wr, bus_err
  );

  modport master (
    output addr, ale, iom_, rd_, wr_, mem_rdata, io_rdata,
    input  ready, mem_addr, mem_wdata, mem_re, mem_we, io_rd, io_wr, bus_err
  );
endinterface

// File: rtl/bus85_mem.sv
// Demultiplexing adapter between core85 pins and a synchronous RAM / IO port bank.
// Latches the low address on ALE, inserts wait states and issues one strobe per bus cycle.
module bus85_mem #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 16,
  parameter int WAITSTATES = 1
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [DATASIZE-1:0] addrdata,
  bus85_mem_if.slave          bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_HOLD
  } state_t;

  localparam logic [2:0] WaitLoad = 3'(WAITSTATES);

  state_t              r_state;
  logic [ADDRSIZE-1:0] r_alat;
  logic                r_iomlat;
  logic [2:0]          r_wcnt;
  logic [DATASIZE-1:0] r_wdata;
  logic [DATASIZE-1:0] r_rbuf;
  logic                r_rbufValid;
  logic                r_memRe;
  logic                r_memWe;
  logic                r_ioRd;
  logic                r_ioWr;
  logic                r_busErr;
  logic                w_drive;

  // Strobes default low every edge so each is a single-cycle pulse; ALE wins over any bus phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alat      <= '0;
      r_iomlat    <= 1'b0;
      r_wcnt      <= 3'd0;
      r_wdata     <= '0;
      r_rbuf      <= '0;
      r_rbufValid <= 1'b0;
      r_memRe     <= 1'b0;
      r_memWe     <= 1'b0;
      r_ioRd      <= 1'b0;
      r_ioWr      <= 1'b0;
      r_busErr    <= 1'b0;
    end else begin
      r_memRe  <= 1'b0;
      r_memWe  <= 1'b0;
      r_ioRd   <= 1'b0;
      r_ioWr   <= 1'b0;
      r_busErr <= 1'b0;

      if (bus.ale) begin
        r_alat   <= {bus.addr, addrdata};
        r_iomlat <= bus.iom_;
        r_wcnt   <= WaitLoad;
      end else if (r_wcnt != 3'd0) begin
        r_wcnt <= r_wcnt - 3'd1;
      end

      if (bus.ale) begin
        r_state     <= S_WAIT;
        r_rbufValid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          // Strobes are held back until the core has been released by ready.
          S_WAIT: begin
            if (r_wcnt == 3'd0) begin
              if (!bus.rd_ && !bus.wr_) begin
                r_busErr <= 1'b1;
                r_state  <= S_HOLD;
              end else if (!bus.rd_) begin
                r_memRe <= !r_iomlat;
                r_ioRd  <= r_iomlat;
                r_state <= S_READ;
              end else if (!bus.wr_) begin
                r_wdata <= addrdata;
                r_memWe <= !r_iomlat;
                r_ioWr  <= r_iomlat;
                r_state <= S_WRITE;
              end
            end
          end
          S_READ: begin
            r_rbuf      <= r_iomlat ? bus.io_rdata : bus.mem_rdata;
            r_rbufValid <= 1'b1;
            r_state     <= S_HOLD;
          end
          S_WRITE: r_state <= S_HOLD;
          S_HOLD: begin
            if (bus.rd_ && bus.wr_) begin
              r_state     <= S_IDLE;
              r_rbufValid <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // The AD bus is only turned around while the core is actively reading buffered data.
  assign w_drive = (r_state == S_HOLD) && r_rbufValid && !bus.rd_ && bus.wr_ && !bus.ale;
  assign addrdata = w_drive ? r_rbuf : {DATASIZE{1'bz}};

  assign bus.ready     = (r_wcnt == 3'd0);
  assign bus.mem_addr  = r_alat;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_re    = r_memRe;
  assign bus.mem_we    = r_memWe;
  assign bus.io_rd     = r_ioRd;
  assign bus.io_wr     = r_ioWr;
  assign bus.bus_err   = r_busErr;

endmodule

// File: tb/tb_bus85_mem.sv
// Directed bench for bus85_mem: one instance with WAITSTATES=1 and one with WAITSTATES=3
// share the same core-side stimulus; the AD nets are pulled high so an undriven bus reads 0xFF.
module tb_bus85_mem;

  localparam int DS = 8;
  localparam int AS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tbAdEn;
  logic [DS-1:0] tbAd;
  tri1  [DS-1:0] addrdata;
  tri1  [DS-1:0] addrdata3;

  int checks = 0;
  int errors = 0;
  int memReCnt = 0, memWeCnt = 0, ioRdCnt = 0, ioWrCnt = 0, busErrCnt = 0;
  int readyLowCnt = 0, ready3LowCnt = 0, memRe3Cnt = 0;

  bus85_mem_if #(.DATASIZE(DS), .ADDRSIZE(AS)) bus ();
  bus85_mem_if #(.DATASIZE(DS), .ADDRSIZE(AS)) bus3 ();

  assign addrdata  = tbAdEn ? tbAd : {DS{1'bz}};
  assign addrdata3 = tbAdEn ? tbAd : {DS{1'bz}};

  assign bus3.addr      = bus.addr;
  assign bus3.ale       = bus.ale;
  assign bus3.iom_      = bus.iom_;
  assign bus3.rd_       = bus.rd_;
  assign bus3.wr_       = bus.wr_;
  assign bus3.mem_rdata = bus.mem_rdata;
  assign bus3.io_rdata  = bus.io_rdata;

  bus85_mem #(.DATASIZE(DS), .ADDRSIZE(AS), .WAITSTATES(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .addrdata (addrdata),
    .bus      (bus.slave)
  );

  bus85_mem #(.DATASIZE(DS), .ADDRSIZE(AS), .WAITSTATES(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .addrdata (addrdata3),
    .bus      (bus3.slave)
  );

  always #5 clk = ~clk;

  // Pulse and wait-state counters, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (bus.mem_re)   memReCnt++;
    if (bus.mem_we)   memWeCnt++;
    if (bus.io_rd)    ioRdCnt++;
    if (bus.io_wr)    ioWrCnt++;
    if (bus.bus_err)  busErrCnt++;
    if (!bus.ready)   readyLowCnt++;
    if (!bus3.ready)  ready3LowCnt++;
    if (bus3.mem_re)  memRe3Cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ale, input logic iom, input logic rd, input logic wr,
                               input logic [7:0] hi, input logic adEn, input logic [7:0] ad);
    bus.ale  = ale;
    bus.iom_ = iom;
    bus.rd_  = rd;
    bus.wr_  = wr;
    bus.addr = hi;
    tbAdEn   = adEn;
    tbAd     = ad;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int base0, base1, base2;
    rst = 1'b1;
    bus.mem_rdata = 8'h00;
    bus.io_rdata  = 8'h00;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    step();
    step();

    checkOutput("rstReady",   32'(bus.ready), 1);
    checkOutput("rstMemAddr", 32'(bus.mem_addr), 'h0000);
    checkOutput("rstStrobes", 32'({bus.mem_re, bus.mem_we, bus.io_rd, bus.io_wr, bus.bus_err}), 0);
    checkOutput("rstWdata",   32'(bus.mem_wdata), 0);
    checkOutput("rstBus",     32'(addrdata), 'hFF);
    rst = 1'b0;

    // Memory read of 0x2000 returning 0x5A
    bus.mem_rdata = 8'h5A;
    base0 = memReCnt;
    base1 = readyLowCnt;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 8'h00);
    step();
    checkOutput("rdReadyLow", 32'(bus.ready), 0);
    checkOutput("rdAddr",     32'(bus.mem_addr), 'h2000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00);
    step();
    checkOutput("rdNoEarlyStrobe", 32'(bus.mem_re), 0);
    checkOutput("rdReadyBack",     32'(bus.ready), 1);
    step();
    checkOutput("rdMemRe",     32'(bus.mem_re), 1);
    checkOutput("rdBusNotYet", 32'(addrdata), 'hFF);
    step();
    checkOutput("rdMemReEnd", 32'(bus.mem_re), 0);
    checkOutput("rdData",     32'(addrdata), 'h5A);
    step();
    checkOutput("rdDataHeld", 32'(addrdata), 'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00);
    #1;
    checkOutput("rdBusReleased", 32'(addrdata), 'hFF);
    step();
    checkOutput("rdOnePulse",       32'(memReCnt - base0), 1);
    checkOutput("rdReadyLowCycles", 32'(readyLowCnt - base1), 1);

    // Memory write of 0xC3 to 0x2001
    base0 = memWeCnt;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 8'h01);
    step();
    checkOutput("wrAddr", 32'(bus.mem_addr), 'h2001);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 8'hC3);
    step();
    checkOutput("wrNoEarlyStrobe", 32'(bus.mem_we), 0);
    step();
    checkOutput("wrMemWe",  32'(bus.mem_we), 1);
    checkOutput("wrData",   32'(bus.mem_wdata), 'hC3);
    checkOutput("wrNoIoWr", 32'(bus.io_wr), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00);
    #1;
    checkOutput("wrBusUndriven", 32'(addrdata), 'hFF);
    step();
    checkOutput("wrMemWeEnd",         32'(bus.mem_we), 0);
    checkOutput("wrBusStillUndriven", 32'(addrdata), 'hFF);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00);
    step();
    checkOutput("wrOnePulse", 32'(memWeCnt - base0), 1);

    // IO write of 0x7E to port 0x10
    base0 = ioWrCnt;
    base1 = memWeCnt;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h10);
    step();
    checkOutput("ioAddr", 32'(bus.mem_addr), 'h0010);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h7E);
    step();
    step();
    checkOutput("ioWr",         32'(bus.io_wr), 1);
    checkOutput("ioWrData",     32'(bus.mem_wdata), 'h7E);
    checkOutput("ioWrNoMemWe",  32'(bus.mem_we), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    step();
    step();
    checkOutput("ioWrOnePulse", 32'(ioWrCnt - base0), 1);
    checkOutput("ioWrNoMem",    32'(memWeCnt - base1), 0);

    // IO read from port 0x10 returning 0x81
    bus.io_rdata = 8'h81;
    base0 = ioRdCnt;
    base1 = memReCnt;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h10);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    step();
    step();
    checkOutput("ioRd",        32'(bus.io_rd), 1);
    checkOutput("ioRdNoMemRe", 32'(bus.mem_re), 0);
    step();
    checkOutput("ioRdData", 32'(addrdata), 'h81);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    step();
    step();
    checkOutput("ioRdOnePulse", 32'(ioRdCnt - base0), 1);
    checkOutput("ioRdNoMem",    32'(memReCnt - base1), 0);

    // Three wait states on the second instance, memory read of 0x3000
    base0 = ready3LowCnt;
    base1 = memRe3Cnt;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h30, 1'b1, 8'h00);
    step();
    checkOutput("ws3ReadyLow1", 32'(bus3.ready), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 8'h00);
    step();
    checkOutput("ws3ReadyLow2", 32'(bus3.ready), 0);
    step();
    checkOutput("ws3ReadyLow3", 32'(bus3.ready), 0);
    checkOutput("ws3NoStrobe",  32'(bus3.mem_re), 0);
    step();
    checkOutput("ws3ReadyHigh",     32'(bus3.ready), 1);
    checkOutput("ws3StillNoStrobe", 32'(bus3.mem_re), 0);
    step();
    checkOutput("ws3MemRe", 32'(bus3.mem_re), 1);
    step();
    checkOutput("ws3Data", 32'(addrdata3), 'h5A);
    checkOutput("ws3Addr", 32'(bus3.mem_addr), 'h3000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 8'h00);
    step();
    step();
    checkOutput("ws3ReadyLowCycles", 32'(ready3LowCnt - base0), 3);
    checkOutput("ws3OnePulse",       32'(memRe3Cnt - base1), 1);

    // rd_ and wr_ low together
    base0 = memReCnt;
    base1 = memWeCnt;
    base2 = busErrCnt;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 8'h02);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 8'h00);
    step();
    checkOutput("errNotYet", 32'(bus.bus_err), 0);
    step();
    checkOutput("errPulse",     32'(bus.bus_err), 1);
    checkOutput("errNoStrobes", 32'({bus.mem_re, bus.mem_we, bus.io_rd, bus.io_wr}), 0);
    step();
    checkOutput("errPulseEnd", 32'(bus.bus_err), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00);
    step();
    step();
    checkOutput("errOnce",        32'(busErrCnt - base2), 1);
    checkOutput("errNoMemStrobe", 32'((memReCnt - base0) + (memWeCnt - base1)), 0);

    // Reset asserted while the read strobe is high
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 8'h00);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00);
    step();
    step();
    checkOutput("rstPreMemRe", 32'(bus.mem_re), 1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidStrobe",  32'(bus.mem_re), 0);
    checkOutput("rstMidReady",   32'(bus.ready), 1);
    checkOutput("rstMidReady3",  32'(bus3.ready), 1);
    checkOutput("rstMidBus",     32'(addrdata), 'hFF);
    checkOutput("rstMidAddr",    32'(bus.mem_addr), 'h0000);
    step();
    rst = 1'b0;
    base0 = memReCnt;
    base1 = memRe3Cnt;
    step();
    step();
    step();
    step();
    checkOutput("rstNoStrobeAfter", 32'((memReCnt - base0) + (memRe3Cnt - base1)), 0);
    checkOutput("rstBusIdle",       32'(addrdata), 'hFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
